// File: rtl/bus_pkg.sv
// ============================================================================
// Module : bus_pkg
// Brief  : Data-bus bridge state encoding and latched request layout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int c_BUS_ADDR_W = 32;
    localparam int c_BUS_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } dbus_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } msize_t;

    typedef struct packed {
        logic                      wr;
        msize_t                    size;
        logic [c_BUS_ADDR_W-1:0]   addr;
        logic [c_BUS_DATA_W/8-1:0] wstrb;
        logic [c_BUS_DATA_W-1:0]   wdata;
    } dbus_req_t;

endpackage

`default_nettype wire

// File: rtl/common_pkg.sv
// ============================================================================
// Module : common
// Brief  : Pipeline-side memory request types shared across the core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package common;

    localparam int c_MEM_ADDR_W = 32;
    localparam int c_MEM_DATA_W = 32;

    typedef struct packed {
        logic                    valid;
        logic [c_MEM_ADDR_W-1:0] addr;
        logic [1:0]              size;
    } mem_read_req;

    typedef struct packed {
        logic                      valid;
        logic [c_MEM_ADDR_W-1:0]   addr;
        logic [1:0]                size;
        logic [c_MEM_DATA_W/8-1:0] strobe;
        logic [c_MEM_DATA_W-1:0]   data;
    } mem_write_req;

endpackage

`default_nettype wire

// File: rtl/dbus_bridge_req_latch.sv
// ============================================================================
// Module : dbus_req_latch
// Brief  : Holds the issued bus request stable until the transaction retires.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_req_latch
    import bus_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      i_load,
    input  dbus_req_t i_req,
    output dbus_req_t o_req
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_req <= '0;
        end else if (i_load) begin
            o_req <= i_req;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dbus_bridge.sv
// ============================================================================
// Module : dbus_bridge
// Brief  : M-stage to single-outstanding SRAM-like data-bus bridge with drain.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbus_bridge
    import bus_pkg::*;
    import common::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  mem_read_req         mread,
    input  mem_write_req        mwrite,
    input  logic                m_advance,
    input  logic                flush,
    output logic [DATA_W-1:0]   rd,
    output logic                d_data_ok,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W/8-1:0] data_wstrb,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    input  logic                data_data_ok
);

    dbus_state_t       r_state;
    dbus_state_t       w_next;
    logic              r_flushed;
    logic              w_flushed;
    logic              w_keep_flush;
    logic [DATA_W-1:0] r_rd;
    logic              w_valid;
    logic              w_load;
    logic              w_req;
    logic              w_ok;
    logic              w_pass;
    dbus_req_t         w_in;
    dbus_req_t         w_bus;
    dbus_req_t         r_req;

    // A write takes priority when the pipeline presents both.
    always_comb begin
        w_valid  = mread.valid | mwrite.valid;
        w_in.wr  = mwrite.valid;
        w_in.size  = msize_t'(mwrite.valid ? mwrite.size : mread.size);
        w_in.addr  = mwrite.valid ? mwrite.addr : mread.addr;
        w_in.wstrb = mwrite.valid ? mwrite.strobe : '0;
        w_in.wdata = mwrite.valid ? mwrite.data : '0;
    end

    dbus_req_latch u_req_latch (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_req  (w_in),
        .o_req  (r_req)
    );

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_req     = 1'b0;
        w_ok      = 1'b1;
        w_pass    = 1'b0;
        w_flushed = r_flushed | flush;
        case (r_state)
            IDLE: begin
                if (w_valid && !flush) begin
                    w_load = 1'b1;
                    w_req  = 1'b1;
                    w_ok   = 1'b0;
                    if (data_addr_ok && data_data_ok) begin
                        w_ok   = 1'b1;
                        w_pass = 1'b1;
                        w_next = m_advance ? IDLE : DONE;
                    end else if (data_addr_ok) begin
                        w_next = WAIT;
                    end else begin
                        w_next = REQ;
                    end
                end
            end
            REQ: begin
                w_req = 1'b1;
                w_ok  = w_flushed;
                if (data_addr_ok && data_data_ok) begin
                    if (w_flushed) begin
                        w_next = IDLE;
                    end else begin
                        w_ok   = 1'b1;
                        w_pass = 1'b1;
                        w_next = m_advance ? IDLE : DONE;
                    end
                end else if (data_addr_ok) begin
                    w_next = w_flushed ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                w_ok = w_flushed;
                if (data_data_ok) begin
                    if (w_flushed) begin
                        w_next = IDLE;
                    end else begin
                        w_ok   = 1'b1;
                        w_pass = 1'b1;
                        w_next = m_advance ? IDLE : DONE;
                    end
                end else if (w_flushed) begin
                    w_next = DRAIN;
                end
            end
            DONE: begin
                if (m_advance || flush) begin
                    w_next = IDLE;
                end
            end
            DRAIN: begin
                if (data_data_ok) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        w_keep_flush = w_flushed && ((w_next == REQ) || (w_next == WAIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_flushed <= 1'b0;
            r_rd      <= '0;
        end else begin
            r_state   <= w_next;
            r_flushed <= w_keep_flush;
            if (w_pass) begin
                r_rd <= data_rdata;
            end
        end
    end

    // Outputs are forced to idle values while reset is high, independent of the clock.
    always_comb begin
        w_bus      = (r_state == IDLE) ? w_in : r_req;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = '0;
        data_addr  = '0;
        data_wstrb = '0;
        data_wdata = '0;
        rd         = '0;
        d_data_ok  = 1'b1;
        if (!reset) begin
            data_req   = w_req;
            data_wr    = w_bus.wr;
            data_size  = w_bus.size;
            data_addr  = w_bus.addr[ADDR_W-1:0];
            data_wstrb = w_bus.wstrb[DATA_W/8-1:0];
            data_wdata = w_bus.wdata[DATA_W-1:0];
            rd         = w_pass ? data_rdata : r_rd;
            d_data_ok  = w_ok;
        end
    end

    a_single_op: assert property (@(posedge clk) disable iff (reset)
        !(mread.valid && mwrite.valid));

endmodule

`default_nettype wire
